// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Multi-channel power-up reset sequencer. Synchronises the release of the
//   external reset to clk, then releases NUM_CH active-low reset outputs in
//   ascending order, one every 2^CNT_SIZE + 1 clocks. Channel 0 is intended
//   for clocking/infrastructure and the highest channel for the CPU core.
//
//   Build option: define RSTSEQ_SOFTRST_EN to enable the synchronous soft
//   reset. Without it, soft_rst_req is accepted but ignored and no logic is
//   built for it.
//
// Parameters
//   NUM_CH    number of reset outputs (>= 1)
//   CNT_SIZE  stretch per channel is 2^CNT_SIZE + 1 clocks (>= 1)
//
// Ports
//   clk           system clock
//   rst_in_n      external reset, async assert, active-low
//   soft_rst_req  synchronous active-high soft-reset request
//   rst_out_n     per-channel resets, async assert, sync release, active-low
//   seq_done      high once every channel has been released
//
// Phase table (derived from rst2_n and stage)
//   phase    | meaning
//   PH_SYNC  | release synchroniser still filling, counter frozen
//   PH_COUNT | stretching before releasing channel 'stage'
//   PH_DONE  | all channels released, counter parked at 0

module reset_sequencer #(
    parameter int NUM_CH   = 3,
    parameter int CNT_SIZE = 4
) (
    input  logic              clk,
    input  logic              rst_in_n,
    input  logic              soft_rst_req,
    output logic [NUM_CH-1:0] rst_out_n,
    output logic              seq_done
);

    localparam int SW = $clog2(NUM_CH + 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_CH - 1);
    localparam logic [SW-1:0] STAGE_DONE = SW'(NUM_CH);
    localparam logic [SW-1:0] STAGE_ONE  = SW'(1);
    localparam logic [CNT_SIZE:0] CNT_ONE = {{CNT_SIZE{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        PH_SYNC  = 2'd0,
        PH_COUNT = 2'd1,
        PH_DONE  = 2'd2
    } phase_t;

    phase_t            phase;
    logic              rst1_n;
    logic              rst2_n;
    logic [CNT_SIZE:0] cnt;
    logic [CNT_SIZE:0] cnt_nxt;
    logic [SW-1:0]     stage;
    logic [SW-1:0]     stage_nxt;
    logic [NUM_CH-1:0] rst_out_n_nxt;
    logic              seq_done_nxt;
    logic              soft_clr;

`ifdef RSTSEQ_SOFTRST_EN
    // Only honoured once the synchroniser has released.
    assign soft_clr = rst2_n & soft_rst_req;
`else
    logic unused_soft_rst_req;
    assign unused_soft_rst_req = soft_rst_req;
    assign soft_clr            = 1'b0;
`endif

    always_comb begin
        phase = PH_COUNT;
        if (!rst2_n) begin
            phase = PH_SYNC;
        end else if (stage >= STAGE_DONE) begin
            phase = PH_DONE;
        end
    end

    always_comb begin
        cnt_nxt       = cnt;
        stage_nxt     = stage;
        rst_out_n_nxt = rst_out_n;
        seq_done_nxt  = seq_done;
        if (soft_clr) begin
            // Soft reset beats a release due on the same edge.
            cnt_nxt       = '0;
            stage_nxt     = '0;
            rst_out_n_nxt = '0;
            seq_done_nxt  = 1'b0;
        end else begin
            case (phase)
                PH_SYNC: begin
                end
                PH_COUNT: begin
                    if (!cnt[CNT_SIZE]) begin
                        cnt_nxt = cnt + CNT_ONE;
                    end else begin
                        // Loop compare avoids indexing with the wider stage.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (stage == SW'(i)) begin
                                rst_out_n_nxt[i] = 1'b1;
                            end
                        end
                        cnt_nxt   = '0;
                        stage_nxt = stage + STAGE_ONE;
                        if (stage == STAGE_LAST) begin
                            seq_done_nxt = 1'b1;
                        end
                    end
                end
                PH_DONE: begin
                    cnt_nxt = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rst1_n    <= 1'b0;
            rst2_n    <= 1'b0;
            cnt       <= '0;
            stage     <= '0;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
        end else begin
            rst1_n    <= 1'b1;
            rst2_n    <= rst1_n;
            cnt       <= cnt_nxt;
            stage     <= stage_nxt;
            rst_out_n <= rst_out_n_nxt;
            seq_done  <= seq_done_nxt;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Self-checking bench for reset_sequencer (NUM_CH=3, CNT_SIZE=4).
//   The reference model tracks the edge count since rst_in_n released and
//   the edge at which the current count origin was set; channel k is
//   expected high once edge >= origin + (k+1)*P.

module tb_reset_sequencer;

    localparam int NUM_CH   = 3;
    localparam int CNT_SIZE = 4;
    localparam int P        = (1 << CNT_SIZE) + 1;

`ifdef RSTSEQ_SOFTRST_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_in_n;
    logic              soft_rst_req;
    logic [NUM_CH-1:0] rst_out_n;
    logic              seq_done;

    int    n_checks;
    int    n_errors;
    int    e;
    int    origin;
    string scen;

    reset_sequencer #(
        .NUM_CH   (NUM_CH),
        .CNT_SIZE (CNT_SIZE)
    ) dut (
        .clk          (clk),
        .rst_in_n     (rst_in_n),
        .soft_rst_req (soft_rst_req),
        .rst_out_n    (rst_out_n),
        .seq_done     (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s/%s t=%0t edge=%0d got=%0h expected=%0h", scen, tag, $time, e, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_out();
        logic [NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) begin
            v[k] = (e >= origin + (k + 1) * P);
        end
        return v;
    endfunction

    task automatic compare_all();
        logic [NUM_CH-1:0] ev;
        ev = exp_out();
        check_val("rst_out_n", 32'(rst_out_n), 32'(ev));
        check_val("seq_done", 32'(seq_done), 32'(ev[NUM_CH-1]));
    endtask

    // One clock: model update on the edge, DUT compared 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (rst_in_n) begin
            e++;
            if (SOFT_EN && soft_rst_req && e >= 3) begin
                origin = e;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drop_async();
        rst_in_n = 1'b0;
        e        = 0;
        origin   = 2;
    endtask

    task automatic power_up(input int low_clks);
        drop_async();
        ticks(low_clks);
        rst_in_n = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        soft_rst_req = 1'b0;
        scen         = "reset";
        drop_async();
        #2;
        check_val("rst_out_n_reset", 32'(rst_out_n), 32'd0);
        check_val("seq_done_reset", 32'(seq_done), 32'd0);

        // Power-up: edges 19, 36, 53.
        scen = "powerup";
        ticks(5);
        rst_in_n = 1'b1;
        ticks(18);
        check_val("ch0_before", 32'(rst_out_n), 32'b000);
        tick();
        check_val("ch0_at19", 32'(rst_out_n), 32'b001);
        ticks(16);
        check_val("ch1_before", 32'(rst_out_n), 32'b001);
        tick();
        check_val("ch1_at36", 32'(rst_out_n), 32'b011);
        ticks(16);
        check_val("done_before", 32'(seq_done), 32'd0);
        tick();
        check_val("ch2_at53", 32'(rst_out_n), 32'b111);
        check_val("done_at53", 32'(seq_done), 32'd1);
        ticks(10);

        // Async abort between edges 30 and 31.
        scen = "abort";
        power_up(2);
        ticks(30);
        #1;
        drop_async();
        #1;
        check_val("abort_out", 32'(rst_out_n), 32'd0);
        check_val("abort_done", 32'(seq_done), 32'd0);
        #4;
        rst_in_n = 1'b1;
        ticks(18);
        check_val("abort_ch0_before", 32'(rst_out_n), 32'b000);
        tick();
        check_val("abort_ch0_at19", 32'(rst_out_n), 32'b001);
        ticks(40);

        // Soft reset after DONE.
        scen = "soft_done";
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        ticks(60);

        // Soft reset colliding with channel 1 release at edge 36.
        scen = "soft_collide";
        power_up(3);
        ticks(35);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        ticks(60);

        // Held soft request after DONE.
        scen = "soft_held";
        soft_rst_req = 1'b1;
        ticks(40);
        soft_rst_req = 1'b0;
        ticks(60);

        // Free toggling of the request after DONE.
        scen = "soft_toggle";
        power_up(2);
        ticks(55);
        for (int i = 0; i < 30; i++) begin
            soft_rst_req = 1'($urandom_range(0, 1));
            tick();
        end
        soft_rst_req = 1'b0;
        ticks(60);

        // Randomised mix of soft pulses and async aborts.
        scen = "random";
        for (int it = 0; it < 20; it++) begin
            power_up($urandom_range(1, 4));
            for (int c = 0; c < 90; c++) begin
                int r;
                r = $urandom_range(0, 99);
                soft_rst_req = (r < 3);
                if (r == 99) begin
                    #2;
                    drop_async();
                    #1;
                    compare_all();
                    #2;
                    if ($urandom_range(0, 1) == 1) begin
                        rst_in_n = 1'b1;
                    end
                end
                tick();
                if (!rst_in_n && $urandom_range(0, 2) == 0) begin
                    rst_in_n = 1'b1;
                end
            end
            soft_rst_req = 1'b0;
            rst_in_n     = 1'b1;
            ticks(60);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
